// File: rtl/btn_bit_pulse.sv
// btn_bit_pulse: conditions two raw push-buttons into a serial bit stream.
// Each button is synchronized and debounced; a two-state press/release FSM
// emits one bit_valid strobe per press (or one conflict strobe when both
// buttons are seen pressed together while idle).
module btn_bit_pulse #(
  parameter int SYNC_STAGES     = 2,      // 2..4 flops per synchronizer
  parameter int DEBOUNCE_CYCLES = 25000,  // stable cycles before deb_x flips
  parameter int CNT_W           = 15      // DEBOUNCE_CYCLES <= 2**CNT_W
) (
  input  logic clk_in,
  input  logic clear_n,
  input  logic inp_0,
  input  logic inp_1,
  output logic bit_valid,
  output logic bit_value,
  output logic conflict,
  output logic deb_0,
  output logic deb_1
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 0 carries inp_0, channel 1 carries inp_1.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [1:0]             sync_out;

  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       deb_q;
  logic [1:0]       deb_d;

  state_e state_q, state_d;
  logic   bit_valid_q, bit_valid_d;
  logic   bit_value_q, bit_value_d;
  logic   conflict_q,  conflict_d;

  assign raw = {inp_1, inp_0};

  // Last synchronizer stage of each channel feeds its debouncer.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sync_out[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  // Synchronizer chains: shift each raw input toward the last stage.
  always_ff @(posedge clk_in or negedge clear_n) begin
    if (!clear_n) begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      for (int c = 0; c < 2; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
      end
    end
  end

  // Debounce next-state: count consecutive disagreeing cycles, flip on the last.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      // NOTE: defaults first so every path assigns every output; without
      // them a missed branch would infer a latch.
      cnt_d[c] = '0;
      deb_d[c] = deb_q[c];
      if (sync_out[c] != deb_q[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          deb_d[c] = sync_out[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_in or negedge clear_n) begin
    if (!clear_n) begin
      for (int c = 0; c < 2; c++) begin
        cnt_q[c] <= '0;
      end
      deb_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      deb_q <= deb_d;
    end
  end

  // Press/release FSM next-state and registered-output next values.
  always_comb begin
    state_d     = state_q;
    bit_valid_d = 1'b0;
    conflict_d  = 1'b0;
    bit_value_d = bit_value_q;
    unique case (state_q)
      IDLE: begin
        if (deb_q[0] && deb_q[1]) begin
          conflict_d = 1'b1;
          state_d    = WAIT_REL;
        end else if (deb_q[0]) begin
          bit_valid_d = 1'b1;
          bit_value_d = 1'b0;
          state_d     = WAIT_REL;
        end else if (deb_q[1]) begin
          bit_valid_d = 1'b1;
          bit_value_d = 1'b1;
          state_d     = WAIT_REL;
        end
      end
      WAIT_REL: begin
        // A second button pressed while the first is held is ignored here.
        if (!deb_q[0] && !deb_q[1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and output registers; reset mid-press aborts with no strobe.
  always_ff @(posedge clk_in or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_valid_q <= bit_valid_d;
      bit_value_q <= bit_value_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_value = bit_value_q;
  assign conflict  = conflict_q;
  assign deb_0     = deb_q[0];
  assign deb_1     = deb_q[1];

endmodule

// File: tb/tb_btn_bit_pulse.sv
// tb_btn_bit_pulse: scoreboard bench for btn_bit_pulse (SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Stimulus pushes expected strobes (kind, value, cycle)
// into a queue; a monitor pops and compares each strobe the DUT produces.
module tb_btn_bit_pulse;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int LAT   = SYNC + DEB + 1;  // press drive -> strobe sample

  typedef struct {
    logic is_conflict;
    logic value;
    int   cyc;
  } exp_t;

  logic clk_in  = 1'b0;
  logic clear_n = 1'b0;
  logic inp_0   = 1'b0;
  logic inp_1   = 1'b0;
  logic bit_valid, bit_value, conflict, deb_0, deb_1;

  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q [$];

  btn_bit_pulse #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (15)
  ) dut (
    .clk_in    (clk_in),
    .clear_n   (clear_n),
    .inp_0     (inp_0),
    .inp_1     (inp_1),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .conflict  (conflict),
    .deb_0     (deb_0),
    .deb_1     (deb_1)
  );

  always #5 clk_in = ~clk_in;

  // Rising-edge counter used to time expected strobes.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Called at the negedge where the press is driven.
  task automatic expect_evt(input logic is_conf, input logic v);
    exp_t e;
    e.is_conflict = is_conf;
    e.value       = v;
    e.cyc         = cyc + LAT;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    check(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Single press of one button with full release and settle time.
  task automatic press_one(input logic which, input int hold);
    if (which) inp_1 = 1'b1; else inp_0 = 1'b1;
    expect_evt(1'b0, which);
    wait_cyc(hold);
    if (which) inp_1 = 1'b0; else inp_0 = 1'b0;
    wait_cyc(12);
  endtask

  initial begin
    int seq [5] = '{1, 1, 0, 1, 1};

    // Strobe monitor: every strobe must match the head of the scoreboard.
    fork
      forever begin
        exp_t e;
        @(negedge clk_in);
        if (clear_n && (bit_valid || conflict)) begin
          check("strobe_exclusive", bit_valid & conflict, 0);
          if (sb_q.size() == 0) begin
            check("spurious_strobe", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("strobe_kind_conflict", conflict, e.is_conflict);
            if (!e.is_conflict) check("bit_value", bit_value, e.value);
            check("strobe_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    // Reset state.
    wait_cyc(3);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_value", bit_value, 0);
    check("rst_conflict",  conflict,  0);
    check("rst_deb_0",     deb_0,     0);
    check("rst_deb_1",     deb_1,     0);
    clear_n = 1'b1;
    wait_cyc(3);

    // 1: clean press of inp_0, deb_0 rises exactly SYNC+DEB edges later.
    inp_0 = 1'b1;
    expect_evt(1'b0, 1'b0);
    wait_cyc(SYNC + DEB - 1);
    check("t1_deb0_before", deb_0, 0);
    wait_cyc(1);
    check("t1_deb0_edge", deb_0, 1);
    wait_cyc(20 - (SYNC + DEB));
    inp_0 = 1'b0;
    wait_cyc(12);
    check("t1_deb0_released", deb_0, 0);
    drain("t1_drain");

    // 2: glitches shorter than the debounce window never reach deb_1.
    for (int k = 0; k < 5; k++) begin
      inp_1 = 1'b1;
      for (int j = 0; j < 3; j++) begin
        wait_cyc(1);
        check("t2_deb1_glitch", deb_1, 0);
      end
      inp_1 = 1'b0;
      wait_cyc(1);
      check("t2_deb1_glitch", deb_1, 0);
    end
    press_one(1'b1, 10);
    drain("t2_drain");

    // 3: simultaneous press flags conflict only, then a lone inp_1 works.
    inp_0 = 1'b1;
    inp_1 = 1'b1;
    expect_evt(1'b1, 1'b0);
    wait_cyc(10);
    inp_0 = 1'b0;
    inp_1 = 1'b0;
    wait_cyc(12);
    press_one(1'b1, 10);
    drain("t3_drain");

    // 4: second button pressed while first is held is ignored.
    inp_0 = 1'b1;
    expect_evt(1'b0, 1'b0);
    wait_cyc(10);
    inp_1 = 1'b1;
    wait_cyc(10);
    inp_0 = 1'b0;
    wait_cyc(10);
    check("t4_deb1_held", deb_1, 1);
    inp_1 = 1'b0;
    wait_cyc(12);
    drain("t4_drain");

    // 5: asynchronous reset mid-hold, button still held after release.
    inp_1 = 1'b1;
    expect_evt(1'b0, 1'b1);
    wait_cyc(LAT + 2);
    drain("t5_first_drain");
    clear_n = 1'b0;
    #1;
    check("t5_async_bit_valid", bit_valid, 0);
    check("t5_async_bit_value", bit_value, 0);
    check("t5_async_conflict",  conflict,  0);
    check("t5_async_deb_0",     deb_0,     0);
    check("t5_async_deb_1",     deb_1,     0);
    wait_cyc(2);
    clear_n = 1'b1;
    expect_evt(1'b0, 1'b1);
    wait_cyc(12);
    inp_1 = 1'b0;
    wait_cyc(12);
    drain("t5_drain");

    // 6: serial entry 1,1,0,1,1 with full releases.
    foreach (seq[i]) press_one(seq[i][0], 10);
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
